// File: rtl/ro_scan_ctrl.sv
// Ring-oscillator scan sequencer: settle, count edges over a window, report (channel, count); RO_SCAN_MINMAX_EN adds min/max stats.
// Latency 1+SETTLE_CYC+window cycles per result; REPORT holds outputs stable until result_ready_i, stalling the scan.
module ro_scan_ctrl #(
    parameter int NUM_CH     = 16,
    parameter int SEL_W      = 4,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              continuous_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    input  logic [WIN_W-1:0]  win_len_i,
    input  logic              mux_y_i,
    output logic [SEL_W-1:0]  select_o,
    output logic              busy_o,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic [SEL_W-1:0]  result_ch_o,
    output logic [CNT_W-1:0]  result_cnt_o,
    output logic              result_ovf_o,
    output logic              done_o
`ifdef RO_SCAN_MINMAX_EN
    ,
    output logic [CNT_W-1:0]  min_cnt_o,
    output logic [CNT_W-1:0]  max_cnt_o,
    output logic [SEL_W-1:0]  min_ch_o,
    output logic [SEL_W-1:0]  max_ch_o
`endif
);

    localparam int ST_W = $clog2(SETTLE_CYC + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_REPORT  = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [WIN_W-1:0]  win_q, win_d, win_cnt_q, win_cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ST_W-1:0]   settle_q, settle_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              res_vld_q, res_vld_d;
    logic [SEL_W-1:0]  res_ch_q, res_ch_d;
    logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
    logic              res_ovf_q, res_ovf_d;
    logic              done_q, done_d;
`ifdef RO_SCAN_MINMAX_EN
    logic [CNT_W-1:0]  min_cnt_q, min_cnt_d, max_cnt_q, max_cnt_d;
    logic [SEL_W-1:0]  min_ch_q, min_ch_d, max_ch_q, max_ch_d;
`endif

    logic              edge_det;
    logic [CNT_W-1:0]  cnt_inc;
    logic              ovf_inc;
    logic [SEL_W-1:0]  start_ch, low_ch, hi_ch;
    logic              hi_found;

    function automatic logic [SEL_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    assign edge_det = sync2_q & ~prev_q;
    assign start_ch = lowest_ch(ch_mask_i);
    assign low_ch   = lowest_ch(mask_q);

    // Saturating count: an edge arriving at all-ones is lost and flagged.
    always_comb begin
        cnt_inc = cnt_q;
        ovf_inc = ovf_q;
        if (edge_det) begin
            if (&cnt_q) ovf_inc = 1'b1;
            else        cnt_inc = cnt_q + 1'b1;
        end
    end

    // Descending scan leaves the smallest enabled channel above sel_q.
    always_comb begin
        hi_ch    = '0;
        hi_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(sel_q))) begin
                hi_ch    = SEL_W'(i);
                hi_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sync1_d   = mux_y_i;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        mask_d    = mask_q;
        win_d     = win_q;
        win_cnt_d = win_cnt_q;
        sel_d     = sel_q;
        settle_d  = settle_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        res_vld_d = res_vld_q;
        res_ch_d  = res_ch_q;
        res_cnt_d = res_cnt_q;
        res_ovf_d = res_ovf_q;
        done_d    = 1'b0;
`ifdef RO_SCAN_MINMAX_EN
        min_cnt_d = min_cnt_q;
        max_cnt_d = max_cnt_q;
        min_ch_d  = min_ch_q;
        max_ch_d  = max_ch_q;
`endif
        if (abort_i && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            res_vld_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if ((|ch_mask_i) && (|win_len_i)) begin
                            mask_d   = ch_mask_i;
                            win_d    = win_len_i;
                            sel_d    = start_ch;
                            settle_d = ST_W'(SETTLE_CYC);
                            state_d  = S_SETTLE;
`ifdef RO_SCAN_MINMAX_EN
                            min_cnt_d = '1;
                            max_cnt_d = '0;
                            min_ch_d  = '0;
                            max_ch_d  = '0;
`endif
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    settle_d = settle_q - 1'b1;
                    if (settle_q == ST_W'(1)) begin
                        win_cnt_d = win_q;
                        cnt_d     = '0;
                        ovf_d     = 1'b0;
                        state_d   = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    cnt_d     = cnt_inc;
                    ovf_d     = ovf_inc;
                    win_cnt_d = win_cnt_q - 1'b1;
                    if (win_cnt_q == WIN_W'(1)) begin
                        res_ch_d  = sel_q;
                        res_cnt_d = cnt_inc;
                        res_ovf_d = ovf_inc;
                        res_vld_d = 1'b1;
                        state_d   = S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (res_vld_q && result_ready_i) begin
                        res_vld_d = 1'b0;
                        state_d   = S_NEXT;
`ifdef RO_SCAN_MINMAX_EN
                        // Strict compares so ties keep the earlier channel.
                        if (res_cnt_q < min_cnt_q) begin
                            min_cnt_d = res_cnt_q;
                            min_ch_d  = res_ch_q;
                        end
                        if (res_cnt_q > max_cnt_q) begin
                            max_cnt_d = res_cnt_q;
                            max_ch_d  = res_ch_q;
                        end
`endif
                    end
                end
                S_NEXT: begin
                    if (hi_found) begin
                        sel_d    = hi_ch;
                        settle_d = ST_W'(SETTLE_CYC);
                        state_d  = S_SETTLE;
                    end else if (continuous_i) begin
                        sel_d    = low_ch;
                        settle_d = ST_W'(SETTLE_CYC);
                        state_d  = S_SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            mask_q    <= '0;
            win_q     <= '0;
            win_cnt_q <= '0;
            sel_q     <= '0;
            settle_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_vld_q <= 1'b0;
            res_ch_q  <= '0;
            res_cnt_q <= '0;
            res_ovf_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef RO_SCAN_MINMAX_EN
            min_cnt_q <= '1;
            max_cnt_q <= '0;
            min_ch_q  <= '0;
            max_ch_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            mask_q    <= mask_d;
            win_q     <= win_d;
            win_cnt_q <= win_cnt_d;
            sel_q     <= sel_d;
            settle_q  <= settle_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            res_vld_q <= res_vld_d;
            res_ch_q  <= res_ch_d;
            res_cnt_q <= res_cnt_d;
            res_ovf_q <= res_ovf_d;
            done_q    <= done_d;
`ifdef RO_SCAN_MINMAX_EN
            min_cnt_q <= min_cnt_d;
            max_cnt_q <= max_cnt_d;
            min_ch_q  <= min_ch_d;
            max_ch_q  <= max_ch_d;
`endif
        end
    end

    assign select_o       = sel_q;
    assign busy_o         = (state_q != S_IDLE);
    assign result_valid_o = res_vld_q;
    assign result_ch_o    = res_ch_q;
    assign result_cnt_o   = res_cnt_q;
    assign result_ovf_o   = res_ovf_q;
    assign done_o         = done_q;
`ifdef RO_SCAN_MINMAX_EN
    assign min_cnt_o = min_cnt_q;
    assign max_cnt_o = max_cnt_q;
    assign min_ch_o  = min_ch_q;
    assign max_ch_o  = max_ch_q;
`endif

endmodule
